rd5_row_sequencer: RTL and testbench
====================================

RD5_ROW_SEQUENCER -- requirements
Module: rd5_row_sequencer

Interface
REQ-001 The block SHALL have parameter ACT_CYC, default 2, giving the number of cycles row_en is held high per access (legal 1..15).
REQ-002 The block SHALL have parameter PRE_CYC, default 1, giving the number of precharge cycles with row_en low after each access (legal 1..15).
REQ-003 The block SHALL have parameter REF_INTERVAL, default 64, giving the number of clk cycles between refresh requests (legal 8..1023).
REQ-004 One clock; reset is asynchronous and active-low. Ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have these ports:
- req  in  2  per-requester access request, level, held until granted.
- addr0  in  5  row address of requester 0.
- addr1  in  5  row address of requester 1.
- gnt  out  2  one-hot, one-cycle grant pulse.
- done  out  1  one-cycle pulse when an access or refresh completes.
- row_addr  out  5  drives the rd5 decoder inputs {A,B,C,D,E}, A = bit 4.
- row_en  out  1  qualifies the decoded row; high only during ACTIVE.
- busy  out  1  high whenever state != IDLE.
- ref_active  out  1  high for the whole of a refresh operation.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, ACTIVE, PRECHARGE.
REQ-007 IDLE -> ACTIVE SHALL occur on a rising edge in IDLE where ref_pending=1 or any req bit is 1. Otherwise the FSM stays in IDLE.
REQ-008 ACTIVE -> PRECHARGE SHALL occur after exactly ACT_CYC cycles in ACTIVE.
REQ-009 PRECHARGE -> IDLE SHALL occur after exactly PRE_CYC cycles in PRECHARGE. At least one IDLE cycle separates consecutive operations.
REQ-010 Arbitration priority, fixed at the IDLE->ACTIVE edge:
- ref_pending first.
- Then round-robin between req[0] and req[1]: the requester not granted most recently wins when both request. A lone requester always wins.
REQ-011 On entering ACTIVE for requester k, the block SHALL:
- assert gnt[k] for exactly the first ACTIVE cycle;
- latch row_addr from addrk as sampled on the transition edge;
- update the round-robin pointer so the other requester is favoured next.
REQ-012 A refresh operation SHALL latch row_addr from the 5-bit refresh row counter. It SHALL assert no gnt bit and SHALL NOT change the round-robin pointer.
REQ-013 row_en SHALL be 1 in every ACTIVE cycle and 0 in all other states. row_addr SHALL stay constant from entry into ACTIVE until the return to IDLE.
REQ-014 done SHALL pulse high for exactly the last PRECHARGE cycle of every operation, including refresh.
REQ-015 ref_active SHALL be 1 throughout the ACTIVE and PRECHARGE states of a refresh operation and 0 otherwise.
REQ-016 Refresh row counter: increments by 1 at the completion of each refresh. It SHALL wrap from 31 to 0.
REQ-017 Refresh timer:
- counts every cycle;
- at REF_INTERVAL-1 it sets ref_pending and restarts from 0;
- ref_pending clears on the edge that starts the refresh;
- an expiry while ref_pending is already 1 SHALL NOT queue a second refresh.
REQ-018 A timer expiry during a requester access SHALL leave that access undisturbed. The refresh is served at the next IDLE.
REQ-019 Changes on req or addrN while busy=1 SHALL have no effect on the current operation.
REQ-020 gnt SHALL never have both bits set, and SHALL never be nonzero while ref_active=1.

Reset
REQ-021 While rst_n=0 the block SHALL hold, independent of clk:
- state IDLE;
- gnt=0, done=0, row_en=0, busy=0, ref_active=0, row_addr=0;
- refresh row counter 0, timer 0, ref_pending 0;
- round-robin pointer favouring requester 0.
REQ-022 Assertion of rst_n mid-operation SHALL force row_en low immediately and abort the operation without a done pulse.
REQ-023 Operation SHALL resume from IDLE on the first rising edge after rst_n deasserts.

Verification
REQ-024 Single access: req=01, addr0=5'd19 in IDLE -> next cycle gnt=01, row_addr=19, row_en high 2 cycles, then 1 PRECHARGE cycle with done=1, then busy=0.
REQ-025 Contention: req=11 held, addr0=3, addr1=28 -> grants alternate 01,10,01,10. row_addr alternates 3,28. Exactly one IDLE cycle between operations.
REQ-026 Refresh: no requests for 64+ cycles -> ref_active operation with row_addr=0, then 1, ...; after 32 refreshes row_addr wraps back to 0; gnt stays 0.
REQ-027 Refresh collision: timer expires while requester 1 is ACTIVE -> access completes unchanged. Refresh starts on the next IDLE edge ahead of a pending req=01.
REQ-028 Reset mid-ACTIVE: rst_n low during the second ACTIVE cycle -> row_en=0 and busy=0 within the same cycle, no done. After release with req=11, requester 0 is granted first.
REQ-029 Parameter sweep: ACT_CYC=1 and PRE_CYC=3 -> row_en high exactly 1 cycle, done on the 3rd PRECHARGE cycle. Checked with assertions on REQ-013, REQ-014 and REQ-020.

Source files
------------

// File: rtl/rd5_row_sequencer.sv
// rd5 row sequencer: arbitrates two requesters and a periodic refresh onto one rd5
// row decoder, sequencing each operation through an activate and precharge window.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no operation; arbitration is decided on the exit edge
// ACTIVE    | row_en high, row_addr latched, lasts ACT_CYC cycles
// PRECHARGE | row_en low, lasts PRE_CYC cycles, done on the last cycle
module rd5_row_sequencer #(
   parameter int ACT_CYC      = 2,
   parameter int PRE_CYC      = 1,
   parameter int REF_INTERVAL = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic [4:0] addr0,
   input  logic [4:0] addr1,
   output logic [1:0] gnt,
   output logic       done,
   output logic [4:0] row_addr,
   output logic       row_en,
   output logic       busy,
   output logic       ref_active
);
   typedef enum logic [1:0] {IDLE, ACTIVE, PRECHARGE} state_t;

   localparam logic [3:0] ACT_LOAD = 4'(ACT_CYC - 1);
   localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);
   localparam logic [9:0] REF_LAST = 10'(REF_INTERVAL - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [9:0] timer_q, timer_d;
   logic       ref_pending_q, ref_pending_d;
   logic [4:0] ref_row_q, ref_row_d;
   logic       rr_q, rr_d;
   logic [1:0] gnt_q, gnt_d;
   logic       done_q, done_d;
   logic [4:0] row_addr_q, row_addr_d;
   logic       row_en_q, row_en_d;
   logic       busy_q, busy_d;
   logic       ref_active_q, ref_active_d;
   logic       pick1;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      timer_d       = timer_q + 10'd1;
      ref_pending_d = ref_pending_q;
      ref_row_d     = ref_row_q;
      rr_d          = rr_q;
      gnt_d         = 2'b00;
      done_d        = 1'b0;
      row_addr_d    = row_addr_q;
      row_en_d      = row_en_q;
      busy_d        = busy_q;
      ref_active_d  = ref_active_q;
      // rr_q names the requester favoured when both are asking
      pick1         = req[1] & (~req[0] | rr_q);

      if (timer_q == REF_LAST) begin
         timer_d       = 10'd0;
         ref_pending_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (ref_pending_q || (req != 2'b00)) begin
               state_d  = ACTIVE;
               cnt_d    = ACT_LOAD;
               row_en_d = 1'b1;
               busy_d   = 1'b1;
               if (ref_pending_q) begin
                  ref_pending_d = 1'b0;
                  ref_active_d  = 1'b1;
                  row_addr_d    = ref_row_q;
               end else if (pick1) begin
                  gnt_d      = 2'b10;
                  row_addr_d = addr1;
                  rr_d       = 1'b0;
               end else begin
                  gnt_d      = 2'b01;
                  row_addr_d = addr0;
                  rr_d       = 1'b1;
               end
            end
         end
         ACTIVE: begin
            if (cnt_q == 4'd0) begin
               state_d  = PRECHARGE;
               cnt_d    = PRE_LOAD;
               row_en_d = 1'b0;
               done_d   = (PRE_LOAD == 4'd0);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         PRECHARGE: begin
            if (cnt_q == 4'd0) begin
               state_d      = IDLE;
               busy_d       = 1'b0;
               ref_active_d = 1'b0;
               if (ref_active_q) ref_row_d = ref_row_q + 5'd1;
            end else begin
               cnt_d  = cnt_q - 4'd1;
               done_d = (cnt_q == 4'd1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         timer_q       <= 10'd0;
         ref_pending_q <= 1'b0;
         ref_row_q     <= 5'd0;
         rr_q          <= 1'b0;
         gnt_q         <= 2'b00;
         done_q        <= 1'b0;
         row_addr_q    <= 5'd0;
         row_en_q      <= 1'b0;
         busy_q        <= 1'b0;
         ref_active_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         timer_q       <= timer_d;
         ref_pending_q <= ref_pending_d;
         ref_row_q     <= ref_row_d;
         rr_q          <= rr_d;
         gnt_q         <= gnt_d;
         done_q        <= done_d;
         row_addr_q    <= row_addr_d;
         row_en_q      <= row_en_d;
         busy_q        <= busy_d;
         ref_active_q  <= ref_active_d;
      end
   end

   assign gnt        = gnt_q;
   assign done       = done_q;
   assign row_addr   = row_addr_q;
   assign row_en     = row_en_q;
   assign busy       = busy_q;
   assign ref_active = ref_active_q;
endmodule

// File: tb/tb_rd5_row_sequencer.sv
// Self-checking bench for rd5_row_sequencer: directed steps plus a grant scoreboard
// and a refresh-row model checked by a cycle monitor.
module tb_rd5_row_sequencer;
   localparam int ACT = 2;
   localparam int PRE = 1;

   logic       clk;
   logic       rst_n;
   logic [1:0] req, gnt;
   logic [4:0] addr0, addr1, row_addr;
   logic       done, row_en, busy, ref_active;

   logic [1:0] req2, gnt2;
   logic [4:0] addr2, row_addr2;
   logic       done2, row_en2, busy2, ref_active2;

   typedef struct packed {
      logic [1:0] gnt;
      logic [4:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   grants = 0;
   int   refs = 0;
   int   ref_gap = 0;
   int   last_gap = 0;
   logic [4:0] wrap_addr = 5'd31;

   rd5_row_sequencer dut (
      .clk(clk), .rst_n(rst_n), .req(req), .addr0(addr0), .addr1(addr1),
      .gnt(gnt), .done(done), .row_addr(row_addr), .row_en(row_en),
      .busy(busy), .ref_active(ref_active)
   );

   rd5_row_sequencer #(.ACT_CYC(1), .PRE_CYC(3), .REF_INTERVAL(1023)) dut2 (
      .clk(clk), .rst_n(rst_n), .req(req2), .addr0(addr2), .addr1(addr2),
      .gnt(gnt2), .done(done2), .row_addr(row_addr2), .row_en(row_en2),
      .busy(busy2), .ref_active(ref_active2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_grants(input int target, input int budget);
      for (int t = 0; t < budget && grants < target; t++) tick();
      chk("grant_wait", 32'(grants >= target), 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_row_en"}, 32'(row_en), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_ref_active"}, 32'(ref_active), 32'd0);
      chk({tag, "_row_addr"}, 32'(row_addr), 32'd0);
      chk({tag, "_busy2"}, 32'(busy2), 32'd0);
      chk({tag, "_row_en2"}, 32'(row_en2), 32'd0);
   endtask

   // Cycle monitor: scoreboard pops on every requester operation start.
   initial begin
      logic       prev_busy, prev_done, op_ref;
      logic [4:0] op_addr, exp_ref_row;
      int         en_cnt, pre_cnt, idle_cnt, cyc, last_ref_cyc;
      exp_t       e;
      prev_busy = 1'b0; prev_done = 1'b0; op_ref = 1'b0; op_addr = 5'd0;
      exp_ref_row = 5'd0; en_cnt = 0; pre_cnt = 0; idle_cnt = 100;
      cyc = 0; last_ref_cyc = -1000;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_busy = 1'b0; prev_done = 1'b0; op_ref = 1'b0;
            exp_ref_row = 5'd0; en_cnt = 0; pre_cnt = 0; idle_cnt = 100;
            cyc = 0; last_ref_cyc = -1000;
            exp_q.delete();
         end else begin
            cyc++;
            chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            chk("gnt_in_refresh", 32'(ref_active && (gnt != 2'b00)), 32'd0);
            if (busy && !prev_busy) begin
               op_ref   = ref_active;
               op_addr  = row_addr;
               last_gap = idle_cnt;
               en_cnt   = 0;
               pre_cnt  = 0;
               chk("start_row_en", 32'(row_en), 32'd1);
               chk("idle_gap", 32'(last_gap >= 1), 32'd1);
               if (ref_active) begin
                  chk("ref_gnt", 32'(gnt), 32'd0);
                  chk("ref_row", 32'(row_addr), 32'(exp_ref_row));
                  if (refs == 32) wrap_addr = row_addr;
                  ref_gap      = cyc - last_ref_cyc;
                  last_ref_cyc = cyc;
                  refs++;
               end else if (exp_q.size() == 0) begin
                  chk("unexpected_op", 32'(gnt), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("grant", 32'(gnt), 32'(e.gnt));
                  chk("grant_addr", 32'(row_addr), 32'(e.addr));
                  grants++;
               end
            end else if (busy) begin
               chk("gnt_pulse", 32'(gnt), 32'd0);
            end
            if (busy) begin
               idle_cnt = 0;
               chk("addr_hold", 32'(row_addr), 32'(op_addr));
               chk("ref_active_hold", 32'(ref_active), 32'(op_ref));
               if (row_en) begin
                  en_cnt++;
                  chk("row_en_after_pre", 32'(pre_cnt), 32'd0);
               end else begin
                  pre_cnt++;
               end
               if (done) begin
                  chk("act_len", 32'(en_cnt), 32'(ACT));
                  chk("pre_len", 32'(pre_cnt), 32'(PRE));
                  if (op_ref) exp_ref_row = exp_ref_row + 5'd1;
               end
            end else begin
               idle_cnt++;
               chk("idle_row_en", 32'(row_en), 32'd0);
               chk("idle_done", 32'(done), 32'd0);
               chk("idle_ref_active", 32'(ref_active), 32'd0);
               if (prev_busy) chk("done_at_end", 32'(prev_done), 32'd1);
            end
            prev_busy = busy;
            prev_done = done;
         end
      end
   end

   initial begin
      logic [2:0] sweep_exp [4];
      int         prev_refs;
      int         gbase;
      rst_n = 1'b1; req = 2'b00; addr0 = 5'd0; addr1 = 5'd0;
      req2 = 2'b00; addr2 = 5'd0;
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("async_reset");
      tick();
      tick();
      chk_reset_outputs("held_reset");
      rst_n = 1'b1;

      // ACT_CYC=1 / PRE_CYC=3 instance: {row_en, done, busy} after the grant cycle
      sweep_exp = '{3'b001, 3'b001, 3'b011, 3'b000};
      req2 = 2'b01; addr2 = 5'd7;
      tick();
      chk("sweep_gnt", 32'(gnt2), 32'd1);
      chk("sweep_row_en", 32'(row_en2), 32'd1);
      chk("sweep_row_addr", 32'(row_addr2), 32'd7);
      chk("sweep_busy", 32'(busy2), 32'd1);
      req2 = 2'b00;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("sweep_seq", 32'({row_en2, done2, busy2}), 32'(sweep_exp[i]));
         chk("sweep_gnt_low", 32'({gnt2, ref_active2}), 32'd0);
      end

      // Contention: alternating grants with one idle cycle between operations
      addr0 = 5'd3; addr1 = 5'd28;
      exp_q.push_back('{2'b01, 5'd3});
      exp_q.push_back('{2'b10, 5'd28});
      exp_q.push_back('{2'b01, 5'd3});
      exp_q.push_back('{2'b10, 5'd28});
      req = 2'b11;
      gbase = grants;
      for (int i = 0; i < 4; i++) begin
         wait_grants(gbase + i + 1, 20);
         if (i > 0) chk("contention_gap", 32'(last_gap), 32'd1);
      end
      req = 2'b00;
      repeat (4) tick();

      // Single access, cycle by cycle
      addr0 = 5'd19;
      exp_q.push_back('{2'b01, 5'd19});
      req = 2'b01;
      tick();
      chk("single_gnt", 32'(gnt), 32'd1);
      chk("single_addr", 32'(row_addr), 32'd19);
      chk("single_en1", 32'({row_en, busy, done}), 32'b110);
      req = 2'b00;
      tick();
      chk("single_en2", 32'({row_en, busy, done, gnt}), 32'b11000);
      tick();
      chk("single_pre", 32'({row_en, busy, done}), 32'b011);
      tick();
      chk("single_idle", 32'({row_en, busy, done}), 32'b000);

      // Idle refresh stream through the row-counter wrap
      prev_refs = refs;
      for (int t = 0; t < 2600 && refs < 34; t++) begin
         tick();
         if (refs != prev_refs) begin
            if (prev_refs > 0) chk("ref_interval", 32'(ref_gap), 32'd64);
            prev_refs = refs;
         end
      end
      chk("ref_count", 32'(refs >= 34), 32'd1);
      chk("ref_wrap_row", 32'(wrap_addr), 32'd0);

      // Timer expires during requester 1's first ACTIVE cycle
      repeat (61) tick();
      addr1 = 5'd9;
      exp_q.push_back('{2'b10, 5'd9});
      req = 2'b10;
      tick();
      chk("coll_gnt", 32'(gnt), 32'd2);
      chk("coll_addr", 32'(row_addr), 32'd9);
      addr0 = 5'd12; addr1 = 5'd21;
      exp_q.push_back('{2'b01, 5'd12});
      req = 2'b01;
      tick();
      chk("coll_hold", 32'({row_en, row_addr}), 32'({1'b1, 5'd9}));
      tick();
      chk("coll_done", 32'({row_en, done, ref_active}), 32'b010);
      tick();
      chk("coll_idle", 32'(busy), 32'd0);
      tick();
      chk("coll_ref_first", 32'({busy, ref_active, gnt}), 32'b1100);
      repeat (4) tick();
      chk("coll_req0_after", 32'({gnt, row_addr}), 32'({2'b01, 5'd12}));
      req = 2'b00;
      repeat (3) tick();

      // Reset during the second ACTIVE cycle
      addr0 = 5'd4; addr1 = 5'd17;
      exp_q.push_back('{2'b10, 5'd17});
      req = 2'b11;
      tick();
      chk("rst_pre_gnt", 32'(gnt), 32'd2);
      tick();
      chk("rst_pre_row_en", 32'(row_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_row_en", 32'(row_en), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      tick();
      tick();
      chk_reset_outputs("abort_held");
      exp_q.push_back('{2'b01, 5'd4});
      exp_q.push_back('{2'b10, 5'd17});
      gbase = grants;
      rst_n = 1'b1;
      tick();
      chk("resume_gnt", 32'({gnt, row_addr}), 32'({2'b01, 5'd4}));
      wait_grants(gbase + 2, 20);
      req = 2'b00;
      repeat (6) tick();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
